// File: rtl/lsu_pkg.sv
// Shared load/store definitions: the decoder's datatype codes and the LSU FSM states.
package lsu_pkg;

    typedef logic [1:0] lsu_datatype_t;

    localparam lsu_datatype_t DT_WORD  = 2'b00;
    localparam lsu_datatype_t DT_BYTEU = 2'b01;
    localparam lsu_datatype_t DT_HALFU = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction with zero
// extension, and misalignment detection. The reserved datatype code behaves as a word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]    addr_lo,
    input  lsu_datatype_t datatype,
    input  logic [31:0]   wdata,
    input  logic [31:0]   rdata,
    output logic [3:0]    be,
    output logic [31:0]   wdata_lanes,
    output logic [31:0]   rdata_ext,
    output logic          misaligned
);

    always_comb begin
        be          = 4'b1111;
        wdata_lanes = wdata;
        rdata_ext   = rdata;
        misaligned  = (addr_lo != 2'b00);
        case (datatype)
            DT_BYTEU: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {24'h0, rdata[{addr_lo, 3'b000} +: 8]};
                misaligned  = 1'b0;
            end
            DT_HALFU: begin
                be          = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {16'h0, (addr_lo[1] ? rdata[31:16] : rdata[15:0])};
                misaligned  = addr_lo[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding data-memory access stage: latches a request, runs req/gnt/rvalid
// against memory and returns a one-cycle response with zero-extended load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_datatype,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t            state_q, state_d;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    lsu_datatype_t         dt_q;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  accept;

    logic [1:0]            al_addr_lo;
    lsu_datatype_t         al_datatype;
    logic [3:0]            al_be;
    logic [31:0]           al_wdata;
    logic [31:0]           al_rdata;
    logic                  al_misaligned;

    // In IDLE the aligner looks at the incoming request so misalignment is known at accept.
    assign al_addr_lo  = (state_q == StIdle) ? req_addr[1:0] : addr_q[1:0];
    assign al_datatype = (state_q == StIdle) ? req_datatype  : dt_q;

    lsu_align u_align (
        .addr_lo     (al_addr_lo),
        .datatype    (al_datatype),
        .wdata       (wdata_q),
        .rdata       (mem_rdata),
        .be          (al_be),
        .wdata_lanes (al_wdata),
        .rdata_ext   (al_rdata),
        .misaligned  (al_misaligned)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (al_misaligned) begin
                        state_d = StResp;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    if (write_q) begin
                        state_d = StResp;
                        rdata_d = '0;
                        err_d   = 1'b0;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    state_d = StResp;
                    rdata_d = al_rdata;
                    err_d   = 1'b0;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dt_q    <= DT_WORD;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                write_q <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                dt_q    <= req_datatype;
            end
        end
    end

    // Memory-side outputs are quiet outside REQ so reset and idle look identical.
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        resp_rdata = rdata_q;
        resp_err   = err_q;
        mem_req    = (state_q == StReq);
        mem_we     = mem_req & write_q;
        mem_addr   = mem_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
        mem_be     = mem_req ? al_be : 4'b0000;
        mem_wdata  = mem_req ? al_wdata : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-lane reference model predicts memory
// traffic and responses; a memory responder and a response monitor check independently.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cycle;
    } sb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mq_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_datatype;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cur_g = 0;
    int cur_r = 1;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    sb_t sb[$];
    mq_t mq[$];
    logic [31:0] ref_mem [256];
    logic [31:0] dev_mem [256];

    load_store_unit #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_datatype (req_datatype),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Access size in bytes, offset in the word; lanes replicate the low bytes of wd.
    function automatic void model(input logic [1:0] dt, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] word,
                                  output logic [3:0] be, output logic [31:0] mwd,
                                  output logic [31:0] ld, output logic mis);
        int off;
        int size;
        off  = int'(addr % 4);
        size = (dt == 2'b01) ? 1 : (dt == 2'b10) ? 2 : 4;
        mis  = (off % size) != 0;
        be   = '0;
        mwd  = '0;
        ld   = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + size) be[i] = 1'b1;
            mwd[8*i +: 8] = wd[8*(i % size) +: 8];
        end
        if (!mis) begin
            for (int i = 0; i < size; i++) ld[8*i +: 8] = word[8*(off + i) +: 8];
        end
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] val);
        ref_mem[addr[9:2]] = val;
        dev_mem[addr[9:2]] = val;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] dt, input int g, input int r);
        logic [3:0]  be;
        logic [31:0] mwd;
        logic [31:0] ld;
        logic        mis;
        int          n;
        sb_t         e;
        mq_t         m;
        n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(req_ready), 32'd1);
        chk("rdata_hold", resp_rdata, last_rdata);
        chk("err_hold", 32'(resp_err), 32'(last_err));
        model(dt, addr, wd, ref_mem[addr[9:2]], be, mwd, ld, mis);
        cur_g   = g;
        cur_r   = r;
        e.rdata = (wr || mis) ? 32'h0 : ld;
        e.err   = mis;
        e.cycle = cyc + (mis ? 1 : (wr ? 2 + g : 2 + g + r));
        sb.push_back(e);
        if (!mis) begin
            m.we    = wr;
            m.addr  = {addr[31:2], 2'b00};
            m.be    = be;
            m.wdata = mwd;
            mq.push_back(m);
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) ref_mem[addr[9:2]][8*i +: 8] = mwd[8*i +: 8];
                end
            end
        end
        req_valid    = 1'b1;
        req_write    = wr;
        req_addr     = addr;
        req_wdata    = wd;
        req_datatype = dt;
        @(negedge clk);
        req_valid    = 1'b0;
        req_write    = 1'($urandom());
        req_addr     = $urandom();
        req_wdata    = $urandom();
        req_datatype = 2'($urandom());
        chk("ready_low_after_accept", 32'(req_ready), 32'd0);
    endtask

    // Memory model: grants after cur_g cycles, returns load data cur_r cycles after grant.
    initial begin : responder
        mq_t         m;
        logic        have_m;
        logic        we;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        int          g;
        int          r;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                g  = cur_g;
                r  = cur_r;
                we = mem_we;
                a  = mem_addr;
                be = mem_be;
                wd = mem_wdata;
                have_m = (mq.size() != 0);
                if (!have_m) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req: got addr %h be %b, expected no request", a, be);
                end else begin
                    m = mq.pop_front();
                    chk("mem_addr", a, m.addr);
                    chk("mem_be", 32'(be), 32'(m.be));
                    chk("mem_we", 32'(we), 32'(m.we));
                    if (m.we) chk("mem_wdata", wd, m.wdata);
                end
                for (int k = 0; k < g; k++) begin
                    @(negedge clk);
                    chk("hold_req", 32'(mem_req), 32'd1);
                    chk("hold_ready", 32'(req_ready), 32'd0);
                    if (have_m) begin
                        chk("hold_addr", mem_addr, m.addr);
                        chk("hold_be", 32'(mem_be), 32'(m.be));
                        if (m.we) chk("hold_wdata", mem_wdata, m.wdata);
                    end
                end
                mem_gnt = 1'b1;
                @(negedge clk);
                mem_gnt = 1'b0;
                chk("req_drop_after_gnt", 32'(mem_req), 32'd0);
                if (we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be[i]) dev_mem[a[9:2]][8*i +: 8] = wd[8*i +: 8];
                    end
                end else begin
                    for (int k = 1; k < r; k++) @(negedge clk);
                    mem_rvalid = 1'b1;
                    mem_rdata  = dev_mem[a[9:2]];
                    @(negedge clk);
                    mem_rvalid = 1'b0;
                    mem_rdata  = $urandom();
                end
            end
        end
    end

    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got rdata %h err %b, expected no response",
                             resp_rdata, resp_err);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("resp_cycle", cyc, e.cycle);
                    last_rdata = e.rdata;
                    last_err   = e.err;
                end
            end
        end
    end

    initial begin : main
        int n;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_datatype = 2'b00;
        for (int i = 0; i < 256; i++) preload(32'(i) << 2, $urandom());
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue(1'b1, 32'h100, 32'hDEADBEEF, 2'b00, 0, 1);
        preload(32'h200, 32'h80112233);
        issue(1'b0, 32'h203, $urandom(), 2'b01, 0, 2);
        preload(32'h10, 32'h0);
        issue(1'b1, 32'h12, 32'h0000ABCD, 2'b10, 0, 1);
        issue(1'b0, 32'h12, $urandom(), 2'b10, 0, 1);
        issue(1'b0, 32'h102, $urandom(), 2'b00, 0, 1);
        issue(1'b0, 32'h101, $urandom(), 2'b10, 0, 1);
        issue(1'b1, 32'h44, $urandom(), 2'b00, 3, 1);

        // Reset while waiting for load data; the late rvalid must be dropped.
        issue(1'b0, 32'h300, $urandom(), 2'b00, 0, 6);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        chk("midrst_mem_be", 32'(mem_be), 32'd0);
        chk("midrst_mem_addr", mem_addr, 32'd0);
        chk("midrst_resp_rdata", resp_rdata, 32'd0);
        chk("midrst_resp_err", 32'(resp_err), 32'd0);
        sb.delete();
        last_rdata = '0;
        last_err   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue(1'b1, 32'h300, 32'h12345678, 2'b00, 0, 1);
        issue(1'b0, 32'h300, $urandom(), 2'b00, 1, 1);

        for (int t = 0; t < 150; t++) begin
            issue(1'($urandom()), 32'($urandom_range(0, 1023)), $urandom(),
                  2'($urandom()), int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
